mult_div_unit: RTL and testbench

//  Multi-cycle MIPS multiply/divide unit with HI/LO registers. Downstream of the register file.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_iter_core.sv | 48 ++++
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: datapath width, op codes, FSM states.
// MDU_DIV_EN (optional macro) enables the divider datapath in the files that import this package.
package mdu_pkg;

    localparam int unsigned MDU_XLEN = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the multiply (shift-add) or restoring divide (shift-subtract) datapath.
// The divide step exists only when MDU_DIV_EN is defined.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   m_i,
`ifdef MDU_DIV_EN
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   rem_i,
    output logic [XLEN-1:0]   rem_o,
`endif
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] mul_acc;

    // Multiplier bits sit in the low half and are consumed LSB first.
    always_comb begin
        sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, m_i} : {(XLEN+1){1'b0}});
        mul_acc = {sum, acc_i[XLEN-1:1]};
    end

`ifdef MDU_DIV_EN
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Dividend bits shift out of the low half MSB first; quotient bits shift in behind them.
    always_comb begin
        shifted = {rem_i, acc_i[XLEN-1]};
        diff    = shifted - {1'b0, m_i};
        acc_o   = mul_acc;
        rem_o   = rem_i;
        if (is_div_i) begin
            acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], ~diff[XLEN]};
            rem_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        end
    end
`else
    always_comb begin
        acc_o = mul_acc;
    end
`endif

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit with HI/LO; owns the FSM, iteration counter, sign flags and HI/LO.
// Define MDU_DIV_EN for the divider; otherwise DIV/DIVU report div_by_zero as unsupported.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CW = $clog2(XLEN);

    mdu_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   m_q, hi_q, lo_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, dbz_q, busy_q, done_q, dbz_pulse_q;
`ifdef MDU_DIV_EN
    logic              div_q, sign_a_q;
    logic [XLEN-1:0]   rem_q, rem_d;
`endif

    logic              sign_a, sign_b, start_div, start_dbz;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res_hi, res_lo;

    always_comb begin
        sign_a    = op_is_signed(op) & rs_data[XLEN-1];
        sign_b    = op_is_signed(op) & rt_data[XLEN-1];
        mag_a     = sign_a ? -rs_data : rs_data;
        mag_b     = sign_b ? -rt_data : rt_data;
        start_div = op_is_div(op);
`ifdef MDU_DIV_EN
        start_dbz = start_div && (rt_data == '0);
`else
        start_dbz = start_div;
`endif
    end

    // Sign fix-up applied while in FIX, written to HI/LO on the way back to IDLE.
    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        res_hi = prod[2*XLEN-1:XLEN];
        res_lo = prod[XLEN-1:0];
`ifdef MDU_DIV_EN
        if (div_q) begin
            res_lo = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            res_hi = sign_a_q ? -rem_q : rem_q;
        end
`endif
    end

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .acc_i    (acc_q),
        .m_i      (m_q),
`ifdef MDU_DIV_EN
        .is_div_i (div_q),
        .rem_i    (rem_q),
        .rem_o    (rem_d),
`endif
        .acc_o    (acc_d)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_q       <= 1'b0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_pulse_q <= 1'b0;
`ifdef MDU_DIV_EN
            div_q       <= 1'b0;
            sign_a_q    <= 1'b0;
            rem_q       <= '0;
`endif
        end else begin
            done_q      <= 1'b0;
            dbz_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        neg_q  <= sign_a ^ sign_b;
                        dbz_q  <= start_dbz;
                        m_q    <= start_div ? mag_b : mag_a;
                        acc_q  <= {{XLEN{1'b0}}, (start_div ? mag_a : mag_b)};
`ifdef MDU_DIV_EN
                        div_q    <= start_div;
                        sign_a_q <= sign_a;
                        rem_q    <= '0;
`endif
                        // A rejected divide waits one extra cycle in FIX so done lands 2 edges after start.
                        if (start_dbz) begin
                            state_q <= ST_FIX;
                            cnt_q   <= CW'(1);
                        end else begin
                            state_q <= ST_RUN;
                            cnt_q   <= CW'(XLEN-1);
                        end
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
`ifdef MDU_DIV_EN
                    rem_q <= rem_d;
`endif
                    if (cnt_q == '0) state_q <= ST_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        dbz_pulse_q <= dbz_q;
                        if (!dbz_q) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_pulse_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model.
// Expectations for DIV/DIVU follow whether MDU_DIV_EN is defined for the build.
module tb_mult_div_unit;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0, rt_data = '0, wdata = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] mhi = '0, mlo = '0;

    mult_div_unit dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: 64-bit products, C-style truncating divide.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] phi, input logic [31:0] plo,
                         output logic [31:0] ehi, output logic [31:0] elo,
                         output bit edbz, output int elat);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ehi = phi; elo = plo; edbz = 1'b0; elat = 33;
        case (o)
            2'b00: begin p = 64'(sa * sb); ehi = p[63:32]; elo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; ehi = p[63:32]; elo = p[31:0]; end
            default: begin
                if (!DIV_EN || b == 32'd0) begin
                    edbz = 1'b1;
                    elat = 2;
                end else if (o == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p = 64'(sq); elo = p[31:0];
                    p = 64'(sr); ehi = p[31:0];
                end else begin
                    elo = a / b;
                    ehi = a % b;
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit with_mt, input bit disturb);
        logic [31:0] ehi, elo;
        bit          edbz;
        int          elat, lat;
        model(o, a, b, mhi, mlo, ehi, elo, edbz, elat);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        if (with_mt) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF; end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (disturb) begin
                case (n)
                    5, 20:   start = 1'b1;
                    10:      begin mthi = 1'b1; wdata = 32'h0000_1234; end
                    default: begin start = 1'b0; mthi = 1'b0; end
                endcase
                rs_data = $urandom;
            end
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        start = 1'b0; mthi = 1'b0;
        chk("latency", 32'(lat), 32'(elat));
        chk("hi", hi, ehi);
        chk("lo", lo, elo);
        chk("div_by_zero", 32'(div_by_zero), 32'(edbz));
        chk("busy_at_done", 32'(busy), 32'd0);
        mhi = ehi; mlo = elo;
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dbz=%0d lat=%0d",
                 o, a, b, hi, lo, div_by_zero, lat);
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [31:0] d);
        mthi = h; mtlo = l; wdata = d;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (h) mhi = d;
        if (l) mlo = d;
        chk("mt_hi", hi, mhi);
        chk("mt_lo", lo, mlo);
        $display("mt hi=%0d lo=%0d data=%08h -> hi=%08h lo=%08h", h, l, d, hi, lo);
    endtask

    initial begin
        int dones;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // IDLE MTHI+MTLO together, then singly
        mt_write(1'b1, 1'b1, 32'hA5A5_A5A5);
        chk("mt_both_hi", hi, 32'hA5A5_A5A5);
        chk("mt_both_lo", lo, 32'hA5A5_A5A5);
        mt_write(1'b1, 1'b0, 32'h1111_2222);
        mt_write(1'b0, 1'b1, 32'h3333_4444);

        // Reset asserted at cycle 10 of a MULT aborts it
        op = 2'b00; rs_data = 32'd12345; rt_data = 32'd678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        mhi = '0; mlo = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        $display("reset mid-op -> hi=%08h lo=%08h dones=%0d", hi, lo, dones);

        // Directed arithmetic corners
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max_hi", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", lo, 32'h0000_0001);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFEB);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
`ifdef MDU_DIV_EN
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
`endif
        run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef MDU_DIV_EN
        chk("div_intmin_lo", lo, 32'h8000_0000);
        chk("div_intmin_hi", hi, 32'h0000_0000);
`endif

        // Starts and MTHI while busy are ignored
        run_op(2'b00, 32'h0001_0003, 32'hFFFF_0005, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_queued_start", 32'(busy), 32'd0);
        end

        // Start with MTHI/MTLO in the same cycle: write dropped, op runs
        run_op(2'b01, 32'd7, 32'd9, 1'b1, 1'b0);

        // Random ops, each launched in the cycle its predecessor signals done
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 1) rb = 32'($urandom_range(1, 15));
            run_op(ro, ra, rb, (i % 5) == 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
